// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_tx scheduler
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP,
    FAULT
  } sched_state_t;

  // Width of a counter that must hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester and uart_tx side signals of the scheduler
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_done;
  logic                           tx_start;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_active;
  logic                           tx_done;

  modport master (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, req_done, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, req_done, tx_start, tx_data
  );

endinterface

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational rotate-priority encoder
// Searches ptr+1, ptr+2, ... modulo N and grants the first asserted request.
module uart_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin sharing of one uart_tx among NUM_REQ producers
// Grants a byte, pulses tx_start, waits for tx_done with a watchdog, then idles GAP_CYCLES.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_sched_if.master            bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int GW = cnt_width(GAP_CYCLES);

  sched_state_t           state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gid_q, gid_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic [TW-1:0]          wd_q, wd_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [NUM_REQ-1:0]     gnt_onehot;
  logic [IW-1:0]          gnt_idx;
  logic                   gnt_any;

  uart_rr_arb #(.N(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any       (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    data_d        = data_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    bus.req_ready = '0;
    bus.req_done  = '0;
    bus.tx_start  = 1'b0;
    timeout_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gating keeps req_ready quiet while reset is held.
        if (!rst && gnt_any && !bus.tx_active) begin
          bus.req_ready = gnt_onehot;
          data_d        = bus.req_data[int'(gnt_idx)*UART_DATA_W +: UART_DATA_W];
          gid_d         = gnt_idx;
          ptr_d         = gnt_idx;
          state_d       = START;
        end
      end
      START: begin
        bus.tx_start = 1'b1;
        wd_d         = '0;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          bus.req_done[gid_q] = 1'b1;
          gap_d               = '0;
          state_d             = GAP;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          state_d     = FAULT;
        end else if (wd_q != {TW{1'b1}}) begin
          wd_d = wd_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q != GW'(GAP_CYCLES)) begin
          gap_d = gap_q + 1'b1;
        end else if (!bus.tx_active) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (!bus.tx_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_data = data_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(4)) b0 ();
  uart_tx_sched_if #(.NUM_REQ(4)) b1 ();

  logic [1:0] gid0, gid1;
  logic       busy0, busy1, to0, to1;

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(12000)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0), .grant_id(gid0), .busy(busy0), .timeout_err(to0)
  );

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(5), .TIMEOUT_CYCLES(50)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .grant_id(gid1), .busy(busy1), .timeout_err(to1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int last0   = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first valid index after the last winner, wrapping around.
  function automatic int rr_pick(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++)
      if (mask[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic frame0(input logic [3:0] mask, input logic [31:0] data,
                        input int dly, input int hold);
    int w;
    b0.req_valid = mask;
    b0.req_data  = data;
    #1;
    w = rr_pick(mask, last0);
    chk("f0_ready", b0.req_ready, 32'(1) << w);
    step();
    chk("f0_start", b0.tx_start, 1);
    chk("f0_data", b0.tx_data, data[w*8 +: 8]);
    chk("f0_gid", gid0, w);
    last0 = w;
    b0.tx_active = 1'b1;
    repeat (dly) begin
      step();
      chk("f0_wait", {b0.tx_start, b0.req_done, b0.req_ready, to0}, 0);
    end
    step();
    b0.tx_done = 1'b1;
    #1;
    chk("f0_done", b0.req_done, 32'(1) << w);
    step();
    b0.tx_done = 1'b0;
    #1;
    chk("f0_gap_busy", busy0, 1);
    for (int i = 0; i < hold; i++) begin
      b0.tx_active = 1'b1;
      #1;
      chk("f0_gap_hold", b0.req_ready, 0);
      step();
    end
    b0.tx_active = 1'b0;
    #1;
    chk("f0_gap_noready", b0.req_ready, 0);
    step();
    chk("f0_idle", busy0, 0);
  endtask

  initial begin
    logic [3:0] m;
    rst          = 1'b1;
    b0.req_valid = '0; b0.req_data = '0; b0.tx_active = 1'b0; b0.tx_done = 1'b0;
    b1.req_valid = '0; b1.req_data = '0; b1.tx_active = 1'b0; b1.tx_done = 1'b0;
    repeat (2) step();

    chk("rst_ready0", b0.req_ready, 0);
    chk("rst_done0", b0.req_done, 0);
    chk("rst_start0", b0.tx_start, 0);
    chk("rst_data0", b0.tx_data, 0);
    chk("rst_gid0", gid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_to0", to0, 0);
    chk("rst_busy1", {busy1, to1, b1.tx_start, b1.req_ready}, 0);
    rst = 1'b0;
    step();

    // All requesters continuously valid: strict rotation from requester 0.
    for (int i = 0; i < 5; i++) begin
      frame0(4'hF, 32'h13121110, 20, 0);
      chk("rr_gid", gid0, i % 4);
      chk("rr_data", b0.tx_data, 8'h10 + (i % 4));
    end
    b0.req_valid = '0;

    // Single requester 2, uart_tx reports done 100 clocks after start.
    frame0(4'b0100, 32'h00A50000, 99, 0);
    chk("single_gid", gid0, 2);
    chk("single_data", b0.tx_data, 8'hA5);
    b0.req_valid = '0;

    // tx_active high in IDLE blocks any grant.
    b0.req_valid = 4'b0001;
    b0.tx_active = 1'b1;
    #1;
    chk("active_block", b0.req_ready, 0);
    b0.req_valid = '0;
    step();
    chk("active_block_busy", busy0, 0);
    b0.tx_active = 1'b0;

    // Randomised traffic against the round-robin model.
    for (int i = 0; i < 25; i++) begin
      m = 4'($urandom_range(0, 15));
      if (m == 4'b0) begin
        b0.req_valid = '0;
        #1;
        chk("rand_none_ready", b0.req_ready, 0);
        step();
        chk("rand_none_busy", busy0, 0);
      end else begin
        frame0(m, $urandom, $urandom_range(0, 30), $urandom_range(0, 2));
      end
    end
    b0.req_valid = '0;
    step();

    // GAP_CYCLES=5 with tx_active lingering one cycle past tx_done.
    b1.req_valid = 4'b0001;
    b1.req_data  = 32'h44332211;
    #1;
    chk("g_ready", b1.req_ready, 4'b0001);
    step();
    chk("g_start", b1.tx_start, 1);
    chk("g_data", b1.tx_data, 8'h11);
    b1.tx_active = 1'b1;
    b1.req_valid = 4'b0010;
    repeat (10) step();
    b1.tx_done = 1'b1;
    #1;
    chk("g_done", b1.req_done, 4'b0001);
    step();
    b1.tx_done = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k == 1) b1.tx_active = 1'b0;
      #1;
      chk("gap_ready", b1.req_ready, (k == 6) ? 32'h2 : 32'h0);
      chk("gap_start", b1.tx_start, 0);
      if (k < 6) step();
    end
    step();
    chk("g2_start", b1.tx_start, 1);
    chk("g2_gid", gid1, 1);
    chk("g2_data", b1.tx_data, 8'h22);

    // Watchdog: tx_done never arrives, error 50 clocks after tx_start.
    b1.req_valid = 4'b0100;
    b1.tx_active = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      chk("to_pulse", to1, (k == 50) ? 1 : 0);
      chk("to_nodone", b1.req_done, 0);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      chk("fault_hold", {busy1, b1.req_ready}, 5'b10000);
      step();
    end
    b1.tx_active = 1'b0;
    step();
    #1;
    chk("fault_next_ready", b1.req_ready, 4'b0100);
    step();
    chk("fault_next_start", b1.tx_start, 1);
    chk("fault_next_gid", gid1, 2);
    chk("fault_next_data", b1.tx_data, 8'h33);
    b1.req_valid = '0;

    // tx_done on the same cycle the watchdog would fire: done wins.
    b1.tx_active = 1'b1;
    repeat (49) step();
    step();
    b1.tx_done = 1'b1;
    #1;
    chk("coin_done", b1.req_done, 4'b0100);
    chk("coin_to", to1, 0);
    step();
    b1.tx_done   = 1'b0;
    b1.tx_active = 1'b0;
    repeat (6) step();
    chk("coin_idle", busy1, 0);

    // Asynchronous reset during WAIT_DONE.
    b1.req_valid = 4'b1001;
    #1;
    chk("pre_rst_ready", b1.req_ready, 4'b1000);
    step();
    b1.tx_active = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", b1.req_ready, 0);
    chk("arst_done", b1.req_done, 0);
    chk("arst_start", b1.tx_start, 0);
    chk("arst_data", b1.tx_data, 0);
    chk("arst_gid", gid1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_to", to1, 0);
    b1.tx_active = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", b1.req_ready, 4'b0001);
    step();
    chk("post_rst_gid", gid1, 0);
    chk("post_rst_start", b1.tx_start, 1);
    b1.req_valid = '0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
